// File: rtl/param_seq_mult.sv
// param_seq_mult: W-cycle radix-2 shift-add multiplier with rising-edge start.
// Define PSM_SIGNED_EN to add the sgn port for two's-complement products.
module param_seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef PSM_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p,
  output logic [W-1:0]   verif_a,
  output logic [W-1:0]   verif_b
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic r_start_q;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0] r_mplier;
  logic [CW-1:0] r_cnt;
  logic w_trig, w_load, w_last, w_ext, w_neg;
  logic [2*W-1:0] w_part, w_sum;
  assign w_trig = start & ~r_start_q;
  assign w_load = (r_state == IDLE) & w_trig;
  assign w_last = (r_state == CALC) & (r_cnt == CW'(W - 1));
  assign busy   = r_state == CALC;
  assign done   = r_state == DONE;
`ifdef PSM_SIGNED_EN
  logic r_sgn;
  // The multiplier's MSB carries negative weight, so the last partial product is subtracted.
  assign w_ext = sgn & a[W-1];
  assign w_neg = r_sgn & w_last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_sgn <= 1'b0;
    else if (w_load) r_sgn <= sgn;
`else
  assign w_ext = 1'b0;
  assign w_neg = 1'b0;
`endif
  assign w_part = r_mplier[0] ? r_mcand : '0;
  assign w_sum  = w_neg ? r_acc - w_part : r_acc + w_part;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_trig ? CALC : IDLE) :
             (r_state == CALC) ? (w_last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      p         <= '0;
      verif_a   <= '0;
      verif_b   <= '0;
    end else begin
      r_start_q <= start;
      if (w_load) begin
        verif_a  <= a;
        verif_b  <= b;
        r_mcand  <= {{W{w_ext}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == CALC) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) p <= w_sum;
      end
    end
  end
endmodule

// File: tb/tb_param_seq_mult.sv
// tb_param_seq_mult: scoreboard bench for W=8 and W=16 instances of param_seq_mult.
`timescale 1ns/1ps
module tb_param_seq_mult;
  typedef struct { logic [15:0] p; logic [7:0] a; logic [7:0] b; int t; } exp8_t;
  typedef struct { logic [31:0] p; logic [15:0] a; logic [15:0] b; int t; } exp16_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start8 = 1'b0, start16 = 1'b0, sgn8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [7:0] va8, vb8;
  logic [31:0] p16;
  logic [15:0] va16, vb16;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp8_t q8[$];
  exp16_t q16[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  param_seq_mult #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef PSM_SIGNED_EN
    .sgn(sgn8),
`endif
    .busy(busy8), .done(done8), .p(p8), .verif_a(va8), .verif_b(vb8));
  param_seq_mult #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
`ifdef PSM_SIGNED_EN
    .sgn(1'b0),
`endif
    .busy(busy16), .done(done16), .p(p16), .verif_a(va16), .verif_b(vb16));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Monitors: each done pulse must match the oldest outstanding operation, including its cycle.
  always @(negedge clk) if (rst && done8) begin
    if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
    else begin
      exp8_t e;
      e = q8.pop_front();
      chk("p8", {16'd0, p8}, {16'd0, e.p});
      chk("verif_a8", {24'd0, va8}, {24'd0, e.a});
      chk("verif_b8", {24'd0, vb8}, {24'd0, e.b});
      chk("lat8", cyc, e.t);
      chk("busy8_at_done", {31'd0, busy8}, 32'd0);
    end
  end
  always @(negedge clk) if (rst && done16) begin
    if (q16.size() == 0) chk("done16_unexpected", 32'd1, 32'd0);
    else begin
      exp16_t e;
      e = q16.pop_front();
      chk("p16", p16, e.p);
      chk("verif_a16", {16'd0, va16}, {16'd0, e.a});
      chk("verif_b16", {16'd0, vb16}, {16'd0, e.b});
      chk("lat16", cyc, e.t);
    end
  end
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] e, input int hold);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    q8.push_back('{e, a, b, cyc + 9});
    @(negedge clk);
    chk("busy8_after_trig", {31'd0, busy8}, 32'd1);
    repeat (hold - 1) @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_p", {16'd0, p8}, 32'd0);
    chk("rst_va", {24'd0, va8}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    op8(8'h81, 8'h13, 1'b0, 16'h0993, 2);
    a8 = 8'h55; b8 = 8'h66;
    repeat (3) @(negedge clk);
    chk("p_hold", {16'd0, p8}, 32'h0993);
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 20);
    op8(8'h00, 8'hA5, 1'b0, 16'h0000, 1);
    op8(8'h80, 8'h80, 1'b0, 16'h4000, 1);
    op8(8'h80, 8'h7F, 1'b0, 16'h3F80, 1);
    op8(8'hFF, 8'h01, 1'b0, 16'h00FF, 1);
`ifdef PSM_SIGNED_EN
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 1);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, 1);
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, 1);
`endif
    // Second rising start and operand change while busy must be ignored.
    a8 = 8'h2B; b8 = 8'h3C; sgn8 = 1'b0; start8 = 1'b1;
    q8.push_back('{16'h0A14, 8'h2B, 8'h3C, cyc + 9});
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    repeat (18) @(negedge clk);
    start8 = 1'b0;
    chk("ignore_va", {24'd0, va8}, 32'h2B);
    chk("ignore_vb", {24'd0, vb8}, 32'h3C);
    chk("ignore_p", {16'd0, p8}, 32'h0A14);
    repeat (3) @(negedge clk);
    // Abort mid-calculation.
    a8 = 8'h55; b8 = 8'h33; start8 = 1'b1;
    q8.push_back('{16'h10EF, 8'h55, 8'h33, cyc + 9});
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_p", {16'd0, p8}, 32'd0);
    chk("abort_va", {24'd0, va8}, 32'd0);
    q8.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", {31'd0, done8}, 32'd0);
    op8(8'h0C, 8'h0D, 1'b0, 16'h009C, 1);
    // W=16 back-to-back, triggers 18 cycles apart.
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    q16.push_back('{32'hFFFE0001, 16'hFFFF, 16'hFFFF, cyc + 17});
    @(negedge clk);
    start16 = 1'b0;
    repeat (17) @(negedge clk);
    a16 = 16'h1234; b16 = 16'h5678; start16 = 1'b1;
    q16.push_back('{32'h06260060, 16'h1234, 16'h5678, cyc + 17});
    @(negedge clk);
    start16 = 1'b0;
    repeat (22) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q16_drained", q16.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_seq_mult.md
PARAM_SEQ_MULT -- requirements
Module: param_seq_mult

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 Port clk SHALL be an input, 1 bit, the system clock; all state SHALL update on the rising edge.
REQ-003 Port rst SHALL be an input, 1 bit, the reset: asynchronous, active-low.
REQ-004 Port start SHALL be an input, 1 bit, the operation request; only its rising edge is significant.
REQ-005 Ports a and b SHALL be inputs, W bits each, the multiplicand and multiplier.
REQ-006 Port sgn SHALL be an input, 1 bit, selecting signed mode; it SHALL exist only when PSM_SIGNED_EN is defined.
REQ-007 Port busy SHALL be an output, 1 bit, high while an operation is in progress (operands locked).
REQ-008 Port done SHALL be an output, 1 bit, a single-cycle completion pulse.
REQ-009 Port p SHALL be an output, 2W bits, the product register.
REQ-010 Ports verif_a and verif_b SHALL be outputs, W bits each, holding the operands actually captured.

Function
REQ-011 The block SHALL register start every cycle into start_q; trigger SHALL be defined as start AND NOT start_q.
REQ-012 The FSM SHALL have states IDLE, CALC and DONE, and SHALL leave reset in IDLE.
REQ-013 In IDLE, when trigger is high at edge T, the block SHALL capture a, b (and sgn) into verif_a, verif_b and internal registers, clear the accumulator and iteration counter, and enter CALC; busy SHALL be 1 from edge T.
REQ-014 CALC SHALL perform one radix-2 shift-add iteration per cycle, LSB of the multiplier first, for exactly W cycles, with no early termination for zero or small operands.
REQ-015 At edge T+W the block SHALL load p with the full 2W-bit product, enter DONE, set done=1 and set busy=0.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; done SHALL be 0 in every other state.
REQ-017 Trigger SHALL be accepted only in IDLE; a rising start in CALC or DONE SHALL be ignored, not queued.
REQ-018 The minimum start-to-start period SHALL therefore be W+2 cycles.
REQ-019 Changes on a or b while busy=1 SHALL have no effect on p, verif_a or verif_b.
REQ-020 p SHALL hold its value from one completion until the next completion or reset.
REQ-021 start held high continuously SHALL produce exactly one operation.
REQ-022 Unsigned result: p SHALL equal a*b modulo 2^(2W), which is exact (no overflow possible).

Reset
REQ-023 When rst is low, the block SHALL immediately force state=IDLE, busy=0, done=0, p=0, verif_a=0, verif_b=0, start_q=0, and clear the accumulator and counter.
REQ-024 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first trigger after release SHALL run a full, correct operation.

Configuration
REQ-025 When PSM_SIGNED_EN is defined, the block SHALL present the sgn port; with captured sgn=1, p SHALL be the exact two's-complement product of a and b. With captured sgn=0, p SHALL be the unsigned product. Latency SHALL be W cycles in both cases.
REQ-026 When PSM_SIGNED_EN is undefined, the block SHALL have no sgn port and SHALL be unsigned only, with identical timing.

Verification
REQ-027 W=8: a=0x81, b=0x13, start high for 2 cycles -> done high exactly 1 cycle at T+8; p=0x0993; verif_a=0x81; verif_b=0x13.
REQ-028 W=8: a=0xFF, b=0xFF -> p=0xFE01; a=0x00, b=0xA5 -> p=0x0000 with the same 8-cycle latency.
REQ-029 W=8 with PSM_SIGNED_EN, sgn=1: 0x80*0x80 -> p=0x4000; 0x80*0x7F -> p=0xC080; 0xFF*0x01 -> p=0xFFFF. The same operands with sgn=0 -> 0x4000, 0x3F80, 0x00FF.
REQ-030 W=8: start held high for 20 cycles, second rising start at T+3, and a/b changed at T+2 -> exactly one done pulse; p computed from the operands captured at T; verif_a and verif_b unchanged.
REQ-031 W=8: rst pulled low at T+4 -> busy=0, done=0, p=0 immediately and no done pulse; after release, 0x0C*0x0D -> p=0x009C.
REQ-032 W=16: 0xFFFF*0xFFFF -> p=0xFFFE0001 at T+16; back-to-back triggers spaced 18 cycles apart are both accepted.
